fifo_burst_drain_ctrl: RTL and testbench

//  Read-side sequencer for the 12-bit sample FIFO (ports wr_en/rd_en/data_in/data_out/full/empty).
//  On a start pulse, or automatically on fifo_full, it drains up to BURST_LEN words.

---
 rtl/fifo_burst_drain_ctrl_if.sv | 21 ++
 rtl/fifo_burst_drain_ctrl.sv | 77 +++++++
 tb/tb_fifo_burst_drain_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_drain_ctrl_if.sv
// fifo_burst_drain_ctrl_if: FIFO read port and consumer stream seen by the burst drain controller.
interface fifo_burst_drain_ctrl_if #(parameter int DATA_W = 12);
    logic              start;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_first;
    logic              m_last;
    modport master (
        input  start, fifo_empty, fifo_full, fifo_data_out, m_ready,
        output fifo_rd_en, m_data, m_valid, m_first, m_last
    );
    modport slave (
        output start, fifo_empty, fifo_full, fifo_data_out, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_first, m_last
    );
endinterface

// File: rtl/fifo_burst_drain_ctrl.sv
// fifo_burst_drain_ctrl: drains up to BURST_LEN FIFO words per burst onto a framed valid/ready stream.
module fifo_burst_drain_ctrl #(
    parameter int DATA_W    = 12,
    parameter int BURST_LEN = 4,
    parameter int AUTO_FULL = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fifo_burst_drain_ctrl_if.master bus,
    output logic                    o_busy,
    output logic [15:0]             o_bursts_done
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic AUTO = (AUTO_FULL != 0);

    typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid, r_first, r_last;
    logic [15:0]       r_bursts;
    logic              w_go, w_acc;

    assign w_go  = (bus.start | (AUTO & bus.fifo_full)) & ~bus.fifo_empty;
    assign w_acc = r_valid & bus.m_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? READ : IDLE;
            READ:    w_next = WAIT;
            WAIT:    w_next = HOLD;
            HOLD:    w_next = w_acc ? (r_last ? IDLE : READ) : HOLD;
            default: w_next = IDLE;
        endcase
    end

    // FIFO data is valid in WAIT; its empty flag there already reflects this read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_bursts <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_go)
                r_cnt <= '0;
            if (r_state == WAIT) begin
                r_data  <= bus.fifo_data_out;
                r_first <= (r_cnt == '0);
                r_last  <= (r_cnt == LAST_CNT) | bus.fifo_empty;
                r_valid <= 1'b1;
            end
            if (r_state == HOLD && w_acc) begin
                r_valid <= 1'b0;
                if (r_last)
                    r_bursts <= r_bursts + 16'd1;
                else
                    r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.fifo_rd_en = (r_state == READ);
    assign bus.m_data     = r_data;
    assign bus.m_valid    = r_valid;
    assign bus.m_first    = r_first;
    assign bus.m_last     = r_last;
    assign o_busy         = (r_state != IDLE);
    assign o_bursts_done  = r_bursts;
endmodule

// File: tb/tb_fifo_burst_drain_ctrl.sv
// tb_fifo_burst_drain_ctrl: directed bench with a registered-output FIFO model of depth 8.
module tb_fifo_burst_drain_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [11:0] din = '0;
    logic        busy;
    logic [15:0] bursts_done;
    int          checks = 0;
    int          failures = 0;
    int          rd_pulses = 0;

    logic [11:0] mem [8];
    logic [2:0]  wp = '0;
    logic [2:0]  rp = '0;
    logic [3:0]  cnt = '0;
    logic [11:0] dout = '0;

    fifo_burst_drain_ctrl_if #(.DATA_W(12)) bus();

    fifo_burst_drain_ctrl #(.DATA_W(12), .BURST_LEN(4), .AUTO_FULL(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.master),
        .o_busy       (busy),
        .o_bursts_done(bursts_done)
    );

    always #5 clk = ~clk;

    assign bus.fifo_empty    = (cnt == 4'd0);
    assign bus.fifo_full     = (cnt == 4'd8);
    assign bus.fifo_data_out = dout;

    always @(posedge clk) begin
        logic w_ok, r_ok;
        w_ok = wr_en && cnt != 4'd8;
        r_ok = bus.fifo_rd_en && cnt != 4'd0;
        if (w_ok) begin
            mem[wp] <= din;
            wp <= wp + 3'd1;
        end
        if (r_ok) begin
            dout <= mem[rp];
            rp <= rp + 3'd1;
        end
        cnt <= cnt + 4'(w_ok) - 4'(r_ok);
        if (bus.fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [11:0] v);
        wr_en = 1'b1;
        din = v;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for a valid word, checks it, then steps past its acceptance
    task automatic expect_word(input string tag, input logic [11:0] d, input logic f, input logic l);
        int n = 0;
        while (!bus.m_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.m_data), 32'(d));
        chk({tag, "_first"}, 32'(bus.m_first), 32'(f));
        chk({tag, "_last"}, 32'(bus.m_last), 32'(l));
        step();
    endtask

    initial begin
        int rd0;
        logic [15:0] bd0;
        bus.start = 1'b0;
        bus.m_ready = 1'b1;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("rst_outs", {bus.m_data, bus.m_first, bus.m_last, bursts_done}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: full burst of four, check latency and framing
        push(12'd100); push(12'd200); push(12'd300); push(12'd400);
        rd0 = rd_pulses;
        pulse_start();
        chk("t1_rd_T1", 32'(bus.fifo_rd_en), 32'd1);
        step();
        chk("t1_rd_T2", 32'(bus.fifo_rd_en), 32'd0);
        chk("t1_valid_T2", 32'(bus.m_valid), 32'd0);
        step();
        chk("t1_valid_T3", 32'(bus.m_valid), 32'd1);
        expect_word("t1_w0", 12'd100, 1'b1, 1'b0);
        expect_word("t1_w1", 12'd200, 1'b0, 1'b0);
        expect_word("t1_w2", 12'd300, 1'b0, 1'b0);
        expect_word("t1_w3", 12'd400, 1'b0, 1'b1);
        step();
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_bursts", 32'(bursts_done), 32'd1);
        chk("t1_rd_pulses", 32'(rd_pulses - rd0), 32'd4);

        // 2: short burst ends on empty
        push(12'd100); push(12'd200);
        rd0 = rd_pulses;
        pulse_start();
        expect_word("t2_w0", 12'd100, 1'b1, 1'b0);
        expect_word("t2_w1", 12'd200, 1'b0, 1'b1);
        step();
        chk("t2_rd_pulses", 32'(rd_pulses - rd0), 32'd2);
        chk("t2_empty", 32'(bus.fifo_empty), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_bursts", 32'(bursts_done), 32'd2);

        // 3: back-pressure on word 200
        push(12'd100); push(12'd200); push(12'd300); push(12'd400);
        pulse_start();
        expect_word("t3_w0", 12'd100, 1'b1, 1'b0);
        bus.m_ready = 1'b0;
        step();
        step();
        rd0 = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {bus.m_valid, bus.fifo_rd_en, bus.m_data}, {1'b1, 1'b0, 12'd200});
            step();
        end
        chk("t3_no_rd", 32'(rd_pulses - rd0), 32'd0);
        bus.m_ready = 1'b1;
        step();
        chk("t3_gap1", 32'(bus.m_valid), 32'd0);
        step();
        chk("t3_gap2", 32'(bus.m_valid), 32'd0);
        step();
        chk("t3_300_at3", 32'(bus.m_valid), 32'd1);
        expect_word("t3_w2", 12'd300, 1'b0, 1'b0);
        expect_word("t3_w3", 12'd400, 1'b0, 1'b1);
        step();
        chk("t3_bursts", 32'(bursts_done), 32'd3);

        // 4: start on an empty FIFO is dropped
        bd0 = bursts_done;
        rd0 = rd_pulses;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("t4_idle", {bus.fifo_rd_en, bus.m_valid, busy}, 32'd0);
            step();
        end
        chk("t4_no_rd", 32'(rd_pulses - rd0), 32'd0);
        chk("t4_bursts", 32'(bursts_done), 32'(bd0));

        // 5: reset while word 2 is held
        for (int i = 1; i <= 6; i++) push(12'(i * 10));
        pulse_start();
        expect_word("t5_w0", 12'd10, 1'b1, 1'b0);
        bus.m_ready = 1'b0;
        step();
        step();
        chk("t5_hold_w1", {bus.m_valid, bus.m_data}, {1'b1, 12'd20});
        rst_n = 1'b0;
        step();
        chk("t5_rst_outs", {bus.m_data, bus.m_valid, bus.m_first, bus.m_last, bus.fifo_rd_en, busy}, 32'd0);
        chk("t5_rst_bursts", 32'(bursts_done), 32'd0);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        step();
        pulse_start();
        expect_word("t5_w2", 12'd30, 1'b1, 1'b0);
        expect_word("t5_w3", 12'd40, 1'b0, 1'b0);
        expect_word("t5_w4", 12'd50, 1'b0, 1'b0);
        expect_word("t5_w5", 12'd60, 1'b0, 1'b1);
        step();
        chk("t5_bursts", 32'(bursts_done), 32'd1);
        chk("t5_empty", 32'(bus.fifo_empty), 32'd1);

        // 6: filling the FIFO starts a burst without start
        for (int i = 1; i <= 7; i++) push(12'(i));
        chk("t6_no_auto_early", 32'(busy), 32'd0);
        push(12'd8);
        chk("t6_full", 32'(bus.fifo_full), 32'd1);
        step();
        chk("t6_auto_rd", 32'(bus.fifo_rd_en), 32'd1);
        expect_word("t6_w0", 12'd1, 1'b1, 1'b0);
        expect_word("t6_w1", 12'd2, 1'b0, 1'b0);
        expect_word("t6_w2", 12'd3, 1'b0, 1'b0);
        expect_word("t6_w3", 12'd4, 1'b0, 1'b1);
        step();
        step();
        chk("t6_idle_after", 32'(busy), 32'd0);
        chk("t6_bursts", 32'(bursts_done), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
